// File: rtl/gshare_bht_pkg.sv
// rtl/gshare_bht_pkg.sv - shared types and helpers for the gshare branch history table
package gshare_bht_pkg;

  localparam int unsigned GSHARE_VLEN      = 64;
  localparam int unsigned GSHARE_HIST_BITS = 8;

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } gshare_state_e;

  typedef struct packed {
    logic                        valid;
    logic [GSHARE_VLEN-1:0]      pc;
    logic                        taken;
    logic [GSHARE_HIST_BITS-1:0] history;
    logic                        mispredict;
  } gshare_update_t;

  typedef struct packed {
    logic                        valid;
    logic                        taken;
    logic [GSHARE_HIST_BITS-1:0] history;
  } gshare_prediction_t;

  // Counter value with only the MSB set; callers slice the low ctr_bits.
  function automatic logic [3:0] weakly_taken(int unsigned ctr_bits);
    return 4'(4'b0001 << (ctr_bits - 1));
  endfunction

endpackage

// File: rtl/gshare_bht_sat_counter.sv
// rtl/gshare_bht_sat_counter.sv - combinational saturating up/down counter step
module gshare_bht_sat_counter #(
  parameter int unsigned CTR_BITS = 2
) (
  input  logic [CTR_BITS-1:0] ctr,
  input  logic                up,
  output logic [CTR_BITS-1:0] ctr_next
);

  always_comb begin
    ctr_next = ctr;
    if (up) begin
      if (ctr != {CTR_BITS{1'b1}}) ctr_next = ctr + CTR_BITS'(1);
    end else begin
      if (ctr != {CTR_BITS{1'b0}}) ctr_next = ctr - CTR_BITS'(1);
    end
  end

endmodule

// File: rtl/gshare_bht.sv
// rtl/gshare_bht.sv - gshare branch history table with speculative GHR and clear sweep
module gshare_bht
  import gshare_bht_pkg::*;
#(
  parameter int unsigned NR_ENTRIES = 1024,
  parameter int unsigned HIST_BITS  = 8,
  parameter int unsigned CTR_BITS   = 2,
  parameter int unsigned VLEN       = 64,
  parameter int unsigned OFFSET     = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 debug_mode_i,
  input  logic [VLEN-1:0]      vpc_i,
  input  logic                 spec_valid_i,
  input  logic                 spec_taken_i,
  input  logic                 upd_valid_i,
  input  logic [VLEN-1:0]      upd_pc_i,
  input  logic                 upd_taken_i,
  input  logic [HIST_BITS-1:0] upd_history_i,
  input  logic                 upd_mispredict_i,
  output logic                 ready_o,
  output logic                 pred_valid_o,
  output logic                 pred_taken_o,
  output logic [HIST_BITS-1:0] pred_history_o
);

  localparam int unsigned IDX = $clog2(NR_ENTRIES);
  localparam logic [3:0] WT_FULL = weakly_taken(CTR_BITS);
  localparam logic [CTR_BITS-1:0] CTR_CLEARED = WT_FULL[CTR_BITS-1:0];

  gshare_state_e        state_q, state_d;
  logic [IDX-1:0]       ptr_q, ptr_d;
  logic [HIST_BITS-1:0] ghr_q, ghr_d;

  logic                valid_q [NR_ENTRIES];
  logic [CTR_BITS-1:0] ctr_q   [NR_ENTRIES];

  logic [IDX-1:0]      lkp_idx, upd_idx;
  logic [CTR_BITS-1:0] upd_ctr_next;
  logic                upd_we;
  logic                unused_pc_bits;

  assign lkp_idx = vpc_i[IDX+OFFSET-1:OFFSET] ^ IDX'(ghr_q);
  assign upd_idx = upd_pc_i[IDX+OFFSET-1:OFFSET] ^ IDX'(upd_history_i);
  assign unused_pc_bits = ^{vpc_i, upd_pc_i};

  assign ready_o = (state_q == ST_RUN);
  assign upd_we  = upd_valid_i & ready_o & ~debug_mode_i;

  gshare_bht_sat_counter #(
    .CTR_BITS(CTR_BITS)
  ) i_sat_counter (
    .ctr     (ctr_q[upd_idx]),
    .up      (upd_taken_i),
    .ctr_next(upd_ctr_next)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ghr_d   = ghr_q;
    case (state_q)
      ST_CLEAR: begin
        ptr_d = ptr_q + IDX'(1);
        if (ptr_q == IDX'(NR_ENTRIES - 1)) state_d = ST_RUN;
      end
      ST_RUN: begin
        // A mispredict restore replaces any speculative shift from the same cycle.
        if (!debug_mode_i) begin
          if (upd_valid_i && upd_mispredict_i) begin
            ghr_d = HIST_BITS'({upd_history_i, upd_taken_i});
          end else if (spec_valid_i) begin
            ghr_d = HIST_BITS'({ghr_q, spec_taken_i});
          end
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
      ghr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ghr_q   <= ghr_d;
    end
  end

  // Table has no reset of its own; the sweep initialises one entry per cycle.
  always_ff @(posedge clk_i) begin
    if (state_q == ST_CLEAR) begin
      valid_q[ptr_q] <= 1'b0;
      ctr_q[ptr_q]   <= CTR_CLEARED;
    end else if (upd_we) begin
      valid_q[upd_idx] <= 1'b1;
      ctr_q[upd_idx]   <= upd_ctr_next;
    end
  end

  assign pred_valid_o   = ready_o & valid_q[lkp_idx];
  assign pred_taken_o   = ready_o & ctr_q[lkp_idx][CTR_BITS-1];
  assign pred_history_o = ghr_q;

endmodule
